// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer.
// Contents:
//   DEF_WIDTH / DEF_CLR_TIMEOUT  default duration/count width and the reset-acknowledge timeout
//   state_e                      sequencer state encoding
//   clr_cnt_width()              width of the CLEAR-phase cycle counter (never narrower than 3 bits)
package timer_pkg;

    localparam int DEF_WIDTH       = 12;
    localparam int DEF_CLR_TIMEOUT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIRE  = 3'd3,
        ST_FLT   = 3'd4
    } state_e;

    // The counter must be able to hold the value CLR_TIMEOUT itself.
    function automatic int clr_cnt_width(input int timeout);
        int w;
        w = 3;
        while ((1 << w) <= timeout) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/timer_seq_top.sv
// Wrapper pairing one timer_sequencer with one timer_sequencer_timer.
// Ports:
//   clk_2K, RESET_N        clock and asynchronous active-low reset
//   REQ, DURATION, ABORT   request interface of the sequencer
//   ACK, BUSY, EXPIRED, FAULT  sequencer status
module timer_seq_top
    import timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CLR_TIMEOUT = DEF_CLR_TIMEOUT
) (
    input  logic             clk_2K,
    input  logic             RESET_N,
    input  logic             REQ,
    input  logic [WIDTH-1:0] DURATION,
    input  logic             ABORT,
    output logic             ACK,
    output logic             BUSY,
    output logic             EXPIRED,
    output logic             FAULT
);

    logic             t_start;
    logic             t_reset;
    logic [WIDTH-1:0] t_count;
    logic             t_done;
    logic             t_rst_ok;

    timer_sequencer #(
        .WIDTH       (WIDTH),
        .CLR_TIMEOUT (CLR_TIMEOUT)
    ) u_seq (
        .clk_2K   (clk_2K),
        .RESET_N  (RESET_N),
        .REQ      (REQ),
        .DURATION (DURATION),
        .ABORT    (ABORT),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .EXPIRED  (EXPIRED),
        .FAULT    (FAULT),
        .T_START  (t_start),
        .T_RESET  (t_reset),
        .T_COUNT  (t_count),
        .T_DONE   (t_done),
        .T_RST_OK (t_rst_ok)
    );

    timer_sequencer_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk_2K  (clk_2K),
        .RESET_N (RESET_N),
        .START   (t_start),
        .RESET   (t_reset),
        .COUNT   (t_count),
        .DONE    (t_done),
        .RST_OK  (t_rst_ok)
    );

endmodule

// File: rtl/timer_sequencer_timer.sv
// Simple up-counting timer used alongside the sequencer in timer_seq_top.
// Ports:
//   clk_2K, RESET_N   clock and asynchronous active-low reset
//   START             count up by one per cycle (saturates at all-ones)
//   RESET             clear the count; acknowledged one cycle later on RST_OK
//   COUNT             current count
//   DONE              count has reached all-ones
//   RST_OK            count has been cleared and no run has started since
module timer_sequencer_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk_2K,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             RESET,
    output logic [WIDTH-1:0] COUNT,
    output logic             DONE,
    output logic             RST_OK
);

    logic [WIDTH-1:0] count_d, count_q;
    logic             done_d, done_q;
    logic             rst_ok_d, rst_ok_q;

    always_comb begin
        count_d  = count_q;
        done_d   = done_q;
        rst_ok_d = rst_ok_q;
        if (RESET) begin
            count_d  = '0;
            done_d   = 1'b0;
            rst_ok_d = 1'b1;
        end else if (START) begin
            rst_ok_d = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + WIDTH'(1);
            end
            done_d = (count_d == '1);
        end
    end

    always_ff @(posedge clk_2K or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q  <= '0;
            done_q   <= 1'b0;
            rst_ok_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            done_q   <= done_d;
            rst_ok_q <= rst_ok_d;
        end
    end

    assign COUNT  = count_q;
    assign DONE   = done_q;
    assign RST_OK = rst_ok_q;

endmodule

// File: rtl/timer_sequencer.sv
// Delay sequencer driving an external timer: on an accepted request it resets
// the timer, waits for the reset acknowledge, runs the timer until the
// requested duration is reached and then pulses EXPIRED.
// Ports:
//   clk_2K, RESET_N          2 kHz clock, asynchronous active-low reset
//   REQ, DURATION            delay request and its length (sampled only in IDLE)
//   ABORT                    cancel any delay in progress (wins over REQ and expiry)
//   ACK                      one-cycle pulse: request accepted
//   BUSY                     high whenever not IDLE
//   EXPIRED                  one-cycle pulse: delay elapsed
//   FAULT                    sticky: timer reset was not acknowledged in time
//   T_START, T_RESET         timer control
//   T_COUNT, T_DONE, T_RST_OK timer status
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CLR_TIMEOUT = DEF_CLR_TIMEOUT
) (
    input  logic             clk_2K,
    input  logic             RESET_N,
    input  logic             REQ,
    input  logic [WIDTH-1:0] DURATION,
    input  logic             ABORT,
    output logic             ACK,
    output logic             BUSY,
    output logic             EXPIRED,
    output logic             FAULT,
    output logic             T_START,
    output logic             T_RESET,
    input  logic [WIDTH-1:0] T_COUNT,
    input  logic             T_DONE,
    input  logic             T_RST_OK
);

    localparam int            CW       = clr_cnt_width(CLR_TIMEOUT);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_TIMEOUT);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] dur_d, dur_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             ack_d, ack_q;
    logic             busy_d, busy_q;
    logic             expired_d, expired_q;
    logic             fault_d, fault_q;
    logic             t_start_d, t_start_q;
    logic             t_reset_d, t_reset_q;

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        cnt_d   = '0;
        fault_d = fault_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ && !ABORT) begin
                    state_d = ST_CLEAR;
                    dur_d   = DURATION;
                    fault_d = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                // cnt_q == 0 marks the first CLEAR cycle, where RST_OK may
                // still reflect a previous reset and is not trusted.
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0 && T_RST_OK) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CLR_LAST) begin
                    state_d = ST_FLT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if ((T_COUNT >= dur_q) || T_DONE) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: state_d = ST_IDLE;
            ST_FLT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered alongside the state they belong to.
        busy_d    = (state_d != ST_IDLE);
        expired_d = (state_d == ST_FIRE);
        t_start_d = (state_d == ST_RUN);
        t_reset_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk_2K or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            dur_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            fault_q   <= 1'b0;
            t_start_q <= 1'b0;
            t_reset_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            fault_q   <= fault_d;
            t_start_q <= t_start_d;
            t_reset_q <= t_reset_d;
        end
    end

    assign ACK     = ack_q;
    assign BUSY    = busy_q;
    assign EXPIRED = expired_q;
    assign FAULT   = fault_q;
    assign T_START = t_start_q;
    assign T_RESET = t_reset_q;

endmodule
